// File: rtl/systolic_pkg.sv
// Shared defaults, pass-state encoding and operand type for the systolic array feeder.
package systolic_pkg;
    localparam int N_DEF      = 4;
    localparam int DW_DEF     = 4;
    localparam int DRAIN_DEF  = 2;
    localparam int STREAM_LEN = 3 * N_DEF - 2;

    typedef enum logic [2:0] {LOAD, CLEAR, STREAM, DRAIN, DONE} state_t;

    typedef logic [DW_DEF-1:0] operand_t;
endpackage

// File: rtl/feeder_buf.sv
// One NxN A/B operand bank: written one beat (A column k, B row k) at a time,
// read combinationally as the diagonally skewed edge lanes for stream step t.
module feeder_buf #(
    parameter int N  = 4,
    parameter int DW = 4,
    parameter int TW = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [$clog2(N)-1:0] widx,
    input  logic [N*DW-1:0]      col_a,
    input  logic [N*DW-1:0]      row_b,
    input  logic [TW-1:0]        t,
    output logic [N*DW-1:0]      a_lanes,
    output logic [N*DW-1:0]      b_lanes
);
    localparam int IW = $clog2(N);

    for (genvar i = 0; i < N; i++) begin : g_lane
        // Lane i owns row i of A and column i of B, so both share the same skew.
        logic [DW-1:0] a_row [N];
        logic [DW-1:0] b_col [N];
        logic [TW-1:0] k;
        logic          hit;

        always_ff @(posedge clk) begin
            if (we) begin
                a_row[widx] <= col_a[i*DW +: DW];
                b_col[widx] <= row_b[i*DW +: DW];
            end
        end

        assign k   = t - TW'(i);
        assign hit = (t >= TW'(i)) && (k < TW'(N));
        assign a_lanes[i*DW +: DW] = hit ? a_row[k[IW-1:0]] : '0;
        assign b_lanes[i*DW +: DW] = hit ? b_col[k[IW-1:0]] : '0;
    end
endmodule

// File: rtl/systolic_feeder.sv
// Loads an A/B operand pair and replays it as skewed, zero-padded edge streams into an NxN systolic array.
// Optional FEEDER_DBUF_EN: ping-pong banks so the next pair loads while the current pass streams.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int DW        = DW_DEF,
    parameter int DRAIN_CYC = DRAIN_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [N*DW-1:0] load_col_a,
    input  logic [N*DW-1:0] load_row_b,
    output logic            acc_clr,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic            busy,
    output logic            done
);
    localparam int SLEN = 3 * N - 2;
    localparam int TW   = $clog2(SLEN + DRAIN_CYC + 1);
    localparam int BW   = $clog2(N + 1);
    localparam int IW   = $clog2(N);

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            ready_q, ready_d;
    logic            clr_q, clr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N*DW-1:0] a_q, a_d, b_q, b_d;
    logic [N*DW-1:0] a_rd, b_rd;
    logic            accept, full_now, swap;

    assign accept   = load_valid && ready_q;
    assign full_now = (beat_q == BW'(N)) || (accept && (beat_q == BW'(N - 1)));

`ifdef FEEDER_DBUF_EN
    logic            rd_bank_q, rd_bank_d;
    logic [N*DW-1:0] a_rd0, b_rd0, a_rd1, b_rd1;

    // Beats always land in the shadow bank (the one not being streamed).
    feeder_buf #(.N(N), .DW(DW), .TW(TW)) u_buf0 (
        .clk(clk), .we(accept && rd_bank_q), .widx(IW'(beat_q)),
        .col_a(load_col_a), .row_b(load_row_b), .t(cnt_d),
        .a_lanes(a_rd0), .b_lanes(b_rd0)
    );
    feeder_buf #(.N(N), .DW(DW), .TW(TW)) u_buf1 (
        .clk(clk), .we(accept && !rd_bank_q), .widx(IW'(beat_q)),
        .col_a(load_col_a), .row_b(load_row_b), .t(cnt_d),
        .a_lanes(a_rd1), .b_lanes(b_rd1)
    );
    assign a_rd      = rd_bank_q ? a_rd1 : a_rd0;
    assign b_rd      = rd_bank_q ? b_rd1 : b_rd0;
    assign rd_bank_d = rd_bank_q ^ swap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_bank_q <= 1'b0;
        else        rd_bank_q <= rd_bank_d;
    end
`else
    feeder_buf #(.N(N), .DW(DW), .TW(TW)) u_buf (
        .clk(clk), .we(accept), .widx(IW'(beat_q)),
        .col_a(load_col_a), .row_b(load_row_b), .t(cnt_d),
        .a_lanes(a_rd), .b_lanes(b_rd)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q + BW'(accept);
        swap    = 1'b0;
        case (state_q)
            LOAD: begin
                if (full_now) begin
                    state_d = CLEAR;
                    swap    = 1'b1;
                end
            end
            CLEAR: begin
                state_d = STREAM;
                cnt_d   = '0;
            end
            STREAM: begin
                if (cnt_q == TW'(SLEN - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == TW'(DRAIN_CYC - 1)) state_d = DONE;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
`ifdef FEEDER_DBUF_EN
                if (full_now) begin
                    state_d = CLEAR;
                    swap    = 1'b1;
                end else begin
                    state_d = LOAD;
                end
`else
                state_d = LOAD;
`endif
            end
            default: state_d = LOAD;
        endcase
        if (swap) beat_d = '0;

        // Outputs are registered, so they are derived from the state being entered.
`ifdef FEEDER_DBUF_EN
        ready_d = (beat_d < BW'(N));
`else
        ready_d = (state_d == LOAD);
`endif
        clr_d  = (state_d == CLEAR);
        busy_d = (state_d == CLEAR) || (state_d == STREAM) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        a_d    = (state_d == STREAM) ? a_rd : '0;
        b_d    = (state_d == STREAM) ? b_rd : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            beat_q  <= '0;
            ready_q <= 1'b1;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            ready_q <= ready_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign load_ready = ready_q;
    assign acc_clr    = clr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign a_out      = a_q;
    assign b_out      = b_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder; stream lanes and an emulated PE grid product are
// compared against matrices held in the bench. Build with FEEDER_DBUF_EN for the ping-pong test.
module tb_systolic_feeder;
    localparam int N         = 4;
    localparam int DW        = 4;
    localparam int DRAIN_CYC = 2;
    localparam int SLEN      = 3 * N - 2;
    localparam int BUSW      = N * DW;

    logic            clk;
    logic            reset;
    logic            load_valid;
    logic            load_ready;
    logic [BUSW-1:0] load_col_a;
    logic [BUSW-1:0] load_row_b;
    logic            acc_clr;
    logic [BUSW-1:0] a_out;
    logic [BUSW-1:0] b_out;
    logic            busy;
    logic            done;

    systolic_feeder #(.N(N), .DW(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_col_a(load_col_a), .load_row_b(load_row_b), .acc_clr(acc_clr),
        .a_out(a_out), .b_out(b_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur_a [N][N];
    int cur_b [N][N];
    int nxt_a [N][N];
    int nxt_b [N][N];
    int a_hist [SLEN][N];
    int b_hist [SLEN][N];
    bit bg_on = 1'b0;
    int bg_k  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BUSW-1:0] exp_a(input int t);
        logic [BUSW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = DW'(cur_a[i][t-i]);
        return v;
    endfunction

    function automatic logic [BUSW-1:0] exp_b(input int t);
        logic [BUSW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = DW'(cur_b[t-j][j]);
        return v;
    endfunction

    // mode 0: random, 1: A=I with B[k][j]=k+1, 2: all ones-saturated (15)
    task automatic gen(input int mode);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                case (mode)
                    1:       begin nxt_a[i][j] = (i == j) ? 1 : 0; nxt_b[i][j] = i + 1; end
                    2:       begin nxt_a[i][j] = 15; nxt_b[i][j] = 15; end
                    default: begin nxt_a[i][j] = int'($urandom_range(0, 15)); nxt_b[i][j] = int'($urandom_range(0, 15)); end
                endcase
            end
    endtask

    task automatic take();
        cur_a = nxt_a;
        cur_b = nxt_b;
    endtask

    task automatic drive_beat(input bit from_nxt, input int k);
        for (int i = 0; i < N; i++) begin
            load_col_a[i*DW +: DW] = DW'(from_nxt ? nxt_a[i][k] : cur_a[i][k]);
            load_row_b[i*DW +: DW] = DW'(from_nxt ? nxt_b[k][i] : cur_b[k][i]);
        end
    endtask

    // One clock; also feeds the background (next-matrix) load when enabled.
    task automatic step();
        bit hs;
        hs = load_valid && load_ready;
        @(posedge clk); #1;
        if (bg_on) begin
            if (hs) bg_k++;
            if (bg_k < N) begin
                load_valid = 1'b1;
                drive_beat(1'b1, bg_k);
            end else begin
                load_valid = 1'b0;
            end
        end
    endtask

    // mode 0: valid held, 1: valid toggling 1,0,1,0, 2: random valid
    task automatic load_mat(input int mode);
        int k;
        int guard;
        bit v;
        bit hs;
        k = 0;
        guard = 0;
        v = 1'b1;
        while (k < N && guard < 200) begin
            load_valid = v;
            if (v) drive_beat(1'b0, k);
            else begin
                load_col_a = BUSW'($urandom);
                load_row_b = BUSW'($urandom);
            end
            hs = v && load_ready;
            @(posedge clk); #1;
            if (hs) k++;
            guard++;
            case (mode)
                1:       v = !v;
                2:       v = bit'($urandom_range(0, 1));
                default: v = 1'b1;
            endcase
        end
        load_valid = 1'b0;
        if (k != N) chk("load_beats", 32'(k), 32'(N));
    endtask

    // Entered on the CLEAR cycle; leaves on the done cycle (or after a mid-pass reset).
    task automatic check_pass(input int abort_t, input bit hold_v);
        chk("clr_pulse", 32'(acc_clr), 32'd1);
        chk("clr_a_zero", 32'(a_out), 32'd0);
        chk("clr_b_zero", 32'(b_out), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        if (hold_v) begin
            load_valid = 1'b1;
            load_col_a = BUSW'($urandom);
            load_row_b = BUSW'($urandom);
        end
        for (int t = 0; t < SLEN; t++) begin
            step();
            for (int i = 0; i < N; i++) begin
                a_hist[t][i] = int'(a_out[i*DW +: DW]);
                b_hist[t][i] = int'(b_out[i*DW +: DW]);
            end
            chk($sformatf("a_out_t%0d", t), 32'(a_out), 32'(exp_a(t)));
            chk($sformatf("b_out_t%0d", t), 32'(b_out), 32'(exp_b(t)));
            chk("stream_clr", 32'(acc_clr), 32'd0);
            chk("stream_busy", 32'(busy), 32'd1);
`ifndef FEEDER_DBUF_EN
            chk("stream_ready", 32'(load_ready), 32'd0);
`endif
            if (t == abort_t) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_a_zero", 32'(a_out), 32'd0);
                chk("rst_b_zero", 32'(b_out), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ready", 32'(load_ready), 32'd1);
                chk("rst_clr", 32'(acc_clr), 32'd0);
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk); #1;
                chk("post_rst_busy", 32'(busy), 32'd0);
                chk("post_rst_ready", 32'(load_ready), 32'd1);
                return;
            end
        end
        for (int d = 0; d < DRAIN_CYC; d++) begin
            step();
            chk("drain_a_zero", 32'(a_out), 32'd0);
            chk("drain_b_zero", 32'(b_out), 32'd0);
            chk("drain_busy", 32'(busy), 32'd1);
            chk("drain_done", 32'(done), 32'd0);
        end
        step();
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        if (hold_v) load_valid = 1'b0;
        // Emulate the PE grid on the captured edge streams: PE(i,j) sees row i delayed j, column j delayed i.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                int emu;
                int ref_v;
                emu = 0;
                ref_v = 0;
                for (int t = 0; t < SLEN; t++)
                    if (t - j >= 0 && t - i >= 0) emu += a_hist[t-j][i] * b_hist[t-i][j];
                for (int k = 0; k < N; k++) ref_v += cur_a[i][k] * cur_b[k][j];
                chk($sformatf("c_%0d_%0d", i, j), 32'(emu), 32'(ref_v));
            end
    endtask

    task automatic idle_check();
        step();
        chk("idle_ready", 32'(load_ready), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        load_col_a = '0;
        load_row_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_acc_clr", 32'(acc_clr), 32'd0);
        chk("rst_a_out", 32'(a_out), 32'd0);
        chk("rst_b_out", 32'(b_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Identity A, B[k][j]=k+1
        gen(1); take(); load_mat(0); check_pass(-1, 1'b0); idle_check();
        // All-15 operands
        gen(2); take(); load_mat(0); check_pass(-1, 1'b0); idle_check();
        // Gapped load_valid 1,0,1,0
        gen(0); take(); load_mat(1); check_pass(-1, 1'b0); idle_check();
        // Reset at STREAM t=5, then a fresh full pass
        gen(0); take(); load_mat(0); check_pass(5, 1'b0);
        gen(0); take(); load_mat(0); check_pass(-1, 1'b0); idle_check();
`ifndef FEEDER_DBUF_EN
        // load_valid held high while streaming must not consume beats
        gen(0); take(); load_mat(2); check_pass(-1, 1'b1); idle_check();
        gen(0); take(); load_mat(0); check_pass(-1, 1'b0); idle_check();
`else
        // Next pair loaded in the background; pass 2 clears the cycle after done
        gen(0); take(); load_mat(0);
        gen(0);
        bg_on = 1'b1;
        bg_k = 0;
        load_valid = 1'b1;
        drive_beat(1'b1, 0);
        check_pass(-1, 1'b0);
        chk("bg_beats", 32'(bg_k), 32'(N));
        bg_on = 1'b0;
        load_valid = 1'b0;
        take();
        step();
        check_pass(-1, 1'b0);
        idle_check();
`endif
        repeat (3) begin
            gen(0); take(); load_mat(2); check_pass(-1, 1'b0); idle_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
